// File: rtl/spi_frame_arb_if.sv
// Requester-side and SPI-core-side signals of the frame arbiter.
// The master modport is the arbiter's view; slave is the view of whatever drives it.
interface spi_frame_arb_if #(
    parameter int LEN_W = 8
);
    logic             req0_i, req1_i;
    logic [LEN_W-1:0] len0_i, len1_i;
    logic             mode0_i, mode1_i;
    logic [7:0]       tx0_data_i, tx1_data_i;
    logic             gnt0_o, gnt1_o;
    logic             dreq0_o, dreq1_o;
    logic             rx_vld0_o, rx_vld1_o;
    logic [7:0]       rx_data_o;
    logic             done0_o, done1_o;
    logic             err_o;
    logic             spi_en_o;
    logic             master_o;
    logic [7:0]       send_data_o;
    logic             load_end_i, convey_end_i, frame_end_i;
    logic [7:0]       rcv_data_i;

    modport master (
        input  req0_i, req1_i, len0_i, len1_i, mode0_i, mode1_i,
        input  tx0_data_i, tx1_data_i,
        input  load_end_i, convey_end_i, frame_end_i, rcv_data_i,
        output gnt0_o, gnt1_o, dreq0_o, dreq1_o, rx_vld0_o, rx_vld1_o,
        output rx_data_o, done0_o, done1_o, err_o,
        output spi_en_o, master_o, send_data_o
    );

    modport slave (
        output req0_i, req1_i, len0_i, len1_i, mode0_i, mode1_i,
        output tx0_data_i, tx1_data_i,
        output load_end_i, convey_end_i, frame_end_i, rcv_data_i,
        input  gnt0_o, gnt1_o, dreq0_o, dreq1_o, rx_vld0_o, rx_vld1_o,
        input  rx_data_o, done0_o, done1_o, err_o,
        input  spi_en_o, master_o, send_data_o
    );
endinterface

// File: rtl/spi_frame_arb.sv
// Two-requester round-robin frame arbiter and byte sequencer in front of the SPI switch.
// Fetches tx bytes from the granted requester, returns rx bytes, and aborts stalled frames.
module spi_frame_arb #(
    parameter int LEN_W = 8,
    parameter int TO_W  = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    spi_frame_arb_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        FETCH,
        LATCH,
        XFER,
        WAITF,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic             sel_q, sel_d;       // owner of the current frame, 1 = requester 1
    logic             last_q, last_d;     // requester granted most recently
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [TO_W-1:0]  wd_q, wd_d, wd_inc;
    logic             setup_q, setup_d;
    logic             abort_q, abort_d;
    logic             master_q, master_d;
    logic             rxv_q, rxv_d;
    logic [7:0]       send_q, send_d;
    logic [7:0]       rxd_q, rxd_d;

    logic             pick1;
    logic             status;
    logic             timeout;
    logic             busy;

    // Requester 1 wins if it is alone, or if both ask and requester 0 was served last.
    assign pick1   = bus.req1_i && (!bus.req0_i || !last_q);
    assign status  = bus.load_end_i || bus.convey_end_i || bus.frame_end_i;
    assign wd_inc  = wd_q + TO_W'(1);
    assign timeout = &wd_inc;
    assign busy    = (state_q != IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            sel_q    <= 1'b0;
            last_q   <= 1'b1;
            cnt_q    <= '0;
            wd_q     <= '0;
            setup_q  <= 1'b0;
            abort_q  <= 1'b0;
            master_q <= 1'b0;
            rxv_q    <= 1'b0;
            send_q   <= 8'h00;
            rxd_q    <= 8'h00;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            wd_q     <= wd_d;
            setup_q  <= setup_d;
            abort_q  <= abort_d;
            master_q <= master_d;
            rxv_q    <= rxv_d;
            send_q   <= send_d;
            rxd_q    <= rxd_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        wd_d     = wd_q;
        setup_d  = setup_q;
        abort_d  = abort_q;
        master_d = master_q;
        rxv_d    = 1'b0;
        send_d   = send_q;
        rxd_d    = rxd_q;

        case (state_q)
            IDLE: begin
                if (bus.req0_i || bus.req1_i) begin
                    sel_d    = pick1;
                    last_d   = pick1;
                    cnt_d    = pick1 ? bus.len1_i : bus.len0_i;
                    master_d = pick1 ? bus.mode1_i : bus.mode0_i;
                    setup_d  = 1'b0;
                    abort_d  = 1'b0;
                    state_d  = SETUP;
                end
            end
            // Two cycles with spi_en high before the first byte so the pad enables settle.
            SETUP: begin
                setup_d = 1'b1;
                if (setup_q) state_d = FETCH;
            end
            FETCH: state_d = LATCH;
            LATCH: begin
                send_d  = sel_q ? bus.tx1_data_i : bus.tx0_data_i;
                wd_d    = '0;
                state_d = XFER;
            end
            XFER: begin
                if (bus.convey_end_i) begin
                    rxd_d = bus.rcv_data_i;
                    rxv_d = 1'b1;
                    wd_d  = '0;
                    if (cnt_q == '0) begin
                        state_d = WAITF;
                    end else begin
                        cnt_d   = cnt_q - LEN_W'(1);
                        state_d = FETCH;
                    end
                end else if (status) begin
                    wd_d = '0;
                end else begin
                    wd_d = wd_inc;
                    if (timeout) begin
                        abort_d = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            WAITF: begin
                if (bus.frame_end_i) begin
                    wd_d    = '0;
                    state_d = DONE;
                end else if (status) begin
                    wd_d = '0;
                end else begin
                    wd_d = wd_inc;
                    if (timeout) begin
                        abort_d = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                master_d = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant and enable stay high through DONE and drop on the return to IDLE.
    assign bus.gnt0_o      = busy && !sel_q;
    assign bus.gnt1_o      = busy &&  sel_q;
    assign bus.dreq0_o     = (state_q == FETCH) && !sel_q;
    assign bus.dreq1_o     = (state_q == FETCH) &&  sel_q;
    assign bus.rx_vld0_o   = rxv_q && !sel_q;
    assign bus.rx_vld1_o   = rxv_q &&  sel_q;
    assign bus.rx_data_o   = rxd_q;
    assign bus.done0_o     = (state_q == DONE) && !sel_q;
    assign bus.done1_o     = (state_q == DONE) &&  sel_q;
    assign bus.err_o       = (state_q == DONE) && abort_q;
    assign bus.spi_en_o    = busy;
    assign bus.master_o    = master_q;
    assign bus.send_data_o = send_q;

endmodule

// File: tb/tb_spi_frame_arb.sv
// Bench for spi_frame_arb: a requester/SPI-core emulator drives frames while
// observations are compared with a round-robin and byte-sequence reference.
module tb_spi_frame_arb;
    localparam int LEN_W = 8;
    localparam int TO_W  = 4;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    int   m_last = 1;
    logic [7:0] txb [256];

    int o_req_cyc, o_gnt_cyc, o_dreq_first, o_ndreq, o_sent_ok, o_nrx, o_rx_ok;
    int o_ndone, o_done_cyc, o_fe_cyc, o_master_bad, o_overlap, o_other_bad, o_timing_bad;
    bit o_err, o_post_ok, o_timeout, o_rst_zero;

    spi_frame_arb_if #(.LEN_W(LEN_W)) bus ();

    spi_frame_arb #(.LEN_W(LEN_W), .TO_W(TO_W)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    logic [26:0] outs_all;
    assign outs_all = {bus.gnt0_o, bus.gnt1_o, bus.dreq0_o, bus.dreq1_o, bus.rx_vld0_o,
                       bus.rx_vld1_o, bus.done0_o, bus.done1_o, bus.err_o, bus.spi_en_o,
                       bus.master_o, bus.send_data_o, bus.rx_data_o};

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic quiet_core();
        bus.convey_end_i = 1'b0;
        bus.frame_end_i  = 1'b0;
        bus.load_end_i   = 1'b0;
        bus.rcv_data_i   = 8'($urandom);
        bus.tx0_data_i   = 8'($urandom);
        bus.tx1_data_i   = 8'($urandom);
    endtask

    task automatic fill_tx();
        for (int i = 0; i < 256; i++) txb[i] = 8'($urandom);
    endtask

    // Round-robin reference: a lone requester wins, otherwise the one not served last.
    function automatic int pick(bit r0, bit r1);
        if (r0 && r1) return (m_last == 1) ? 0 : 1;
        return r0 ? 0 : 1;
    endfunction

    // Plays requester 'who' and the SPI core for one frame, recording what the DUT did.
    task automatic do_frame(input int who, input logic [7:0] len, input bit mode, input bit keep,
                            input bit stall, input bit stray, input int rst_after);
        int send_cyc, tx_cyc, conv_cyc, last_conv, k, budget;
        bit fin, gw, dw, rw, dn, othr, do_rst;
        send_cyc = -1; tx_cyc = -1; conv_cyc = -1; last_conv = -100; k = 0;
        budget = 60 + (int'(len) + 1) * 16;
        fin = 1'b0;
        o_gnt_cyc = -1; o_dreq_first = -1; o_ndreq = 0; o_sent_ok = 0; o_nrx = 0; o_rx_ok = 0;
        o_ndone = 0; o_done_cyc = -1; o_fe_cyc = -1; o_master_bad = 0; o_overlap = 0;
        o_other_bad = 0; o_timing_bad = 0; o_err = 0; o_post_ok = 0; o_timeout = 0; o_rst_zero = 0;
        if (who == 0) begin bus.req0_i = 1'b1; bus.len0_i = len; bus.mode0_i = mode; end
        else          begin bus.req1_i = 1'b1; bus.len1_i = len; bus.mode1_i = mode; end
        o_req_cyc = cyc;
        while (!fin) begin
            tick();
            quiet_core();
            do_rst = 1'b0;
            gw   = (who == 0) ? bus.gnt0_o    : bus.gnt1_o;
            dw   = (who == 0) ? bus.dreq0_o   : bus.dreq1_o;
            rw   = (who == 0) ? bus.rx_vld0_o : bus.rx_vld1_o;
            dn   = (who == 0) ? bus.done0_o   : bus.done1_o;
            othr = (who == 0) ? (bus.dreq1_o || bus.rx_vld1_o || bus.done1_o)
                              : (bus.dreq0_o || bus.rx_vld0_o || bus.done0_o);
            if (cyc == tx_cyc && o_ndreq > 0) begin
                if (who == 0) bus.tx0_data_i = txb[o_ndreq-1];
                else          bus.tx1_data_i = txb[o_ndreq-1];
            end
            if (bus.gnt0_o && bus.gnt1_o) o_overlap++;
            if (gw && o_gnt_cyc < 0) o_gnt_cyc = cyc;
            if (gw && bus.master_o !== mode) o_master_bad++;
            if (othr || (bus.err_o && !dn)) o_other_bad++;
            if (dw) begin
                if (o_ndreq > 0 && cyc != last_conv + 1) o_timing_bad++;
                if (o_ndreq == 0) o_dreq_first = cyc;
                o_ndreq++;
                tx_cyc   = cyc + 1;
                send_cyc = cyc + 2;
            end
            if (rw) begin
                if (cyc != last_conv + 1) o_timing_bad++;
                if (o_nrx < 256 && bus.rx_data_o === ~txb[o_nrx]) o_rx_ok++;
                o_nrx++;
                if (o_nrx == int'(len) + 1) o_fe_cyc = cyc + int'($urandom_range(0, 3));
                if (o_nrx == rst_after) do_rst = 1'b1;
            end
            if (cyc == send_cyc) begin
                if (k < 256 && bus.send_data_o === txb[k]) o_sent_ok++;
                k++;
                if (!stall) conv_cyc = (stray && k == 1) ? cyc + 2 : cyc + int'($urandom_range(0, 3));
                if (stray && k == 1) bus.frame_end_i = 1'b1;
            end
            if (cyc == conv_cyc) begin
                bus.convey_end_i = 1'b1;
                bus.rcv_data_i   = ~bus.send_data_o;
                last_conv        = cyc;
            end
            if (cyc == o_fe_cyc) bus.frame_end_i = 1'b1;
            if (do_rst) begin
                rst_i = 1'b1;
                tick();
                quiet_core();
                o_rst_zero = (outs_all === 27'd0);
                rst_i = 1'b0;
                bus.req0_i = 1'b0;
                bus.req1_i = 1'b0;
                fin = 1'b1;
            end else if (dn) begin
                o_ndone++;
                o_done_cyc = cyc;
                o_err = bus.err_o;
                if (!keep) begin
                    if (who == 0) bus.req0_i = 1'b0; else bus.req1_i = 1'b0;
                end
                tick();
                quiet_core();
                o_post_ok = !((who == 0) ? bus.gnt0_o : bus.gnt1_o) && !bus.spi_en_o &&
                            !bus.done0_o && !bus.done1_o && !bus.err_o;
                fin = 1'b1;
            end else if (cyc - o_req_cyc > budget) begin
                o_timeout = 1'b1;
                if (who == 0) bus.req0_i = 1'b0; else bus.req1_i = 1'b0;
                fin = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        bus.req0_i = 1'b0; bus.req1_i = 1'b0;
        bus.len0_i = '0; bus.len1_i = '0; bus.mode0_i = 1'b0; bus.mode1_i = 1'b0;
        quiet_core();
        repeat (3) tick();
        n_vec++; if (outs_all !== 27'd0) begin n_bad++; $display("FAIL reset.outputs got %h want 0", outs_all); end
        rst_i = 1'b0;
        m_last = 1;
        tick();
        n_vec++; if (outs_all !== 27'd0) begin n_bad++; $display("FAIL reset.idle got %h want 0", outs_all); end
    endtask

    task automatic test_single_frame();
        txb[0] = 8'hA5; txb[1] = 8'h3C; txb[2] = 8'h0F;
        m_last = pick(1, 0);
        do_frame(0, 8'd2, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        n_vec++; if (o_gnt_cyc !== o_req_cyc + 1) begin n_bad++; $display("FAIL single.gnt_lat got %0d want %0d", o_gnt_cyc - o_req_cyc, 1); end
        n_vec++; if (o_dreq_first !== o_gnt_cyc + 2) begin n_bad++; $display("FAIL single.dreq_lat got %0d want %0d", o_dreq_first - o_gnt_cyc, 2); end
        n_vec++; if (o_ndreq !== 3) begin n_bad++; $display("FAIL single.dreq_count got %0d want 3", o_ndreq); end
        n_vec++; if (o_sent_ok !== 3) begin n_bad++; $display("FAIL single.send_data got %0d good want 3", o_sent_ok); end
        n_vec++; if (o_nrx !== 3 || o_rx_ok !== 3) begin n_bad++; $display("FAIL single.rx got %0d/%0d good want 3/3", o_nrx, o_rx_ok); end
        n_vec++; if (o_ndone !== 1 || o_err !== 1'b0) begin n_bad++; $display("FAIL single.done got %0d err %0d want 1 err 0", o_ndone, o_err); end
        n_vec++; if (o_done_cyc !== o_fe_cyc + 1) begin n_bad++; $display("FAIL single.done_lat got %0d want 1", o_done_cyc - o_fe_cyc); end
        n_vec++; if (o_master_bad !== 0) begin n_bad++; $display("FAIL single.master got %0d bad cycles want 0", o_master_bad); end
        n_vec++; if (o_timing_bad !== 0 || o_other_bad !== 0 || !o_post_ok)
            begin n_bad++; $display("FAIL single.timing got %0d/%0d/%0d want 0/0/1", o_timing_bad, o_other_bad, o_post_ok); end
    endtask

    task automatic test_slave_mode();
        fill_tx();
        m_last = pick(0, 1);
        do_frame(1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        n_vec++; if (o_gnt_cyc !== o_req_cyc + 1) begin n_bad++; $display("FAIL slave.gnt_lat got %0d want 1", o_gnt_cyc - o_req_cyc); end
        n_vec++; if (o_master_bad !== 0) begin n_bad++; $display("FAIL slave.master got %0d bad cycles want 0", o_master_bad); end
        n_vec++; if (o_ndreq !== 1 || o_nrx !== 1 || o_rx_ok !== 1)
            begin n_bad++; $display("FAIL slave.bytes got dreq %0d rx %0d good %0d want 1/1/1", o_ndreq, o_nrx, o_rx_ok); end
        n_vec++; if (o_ndone !== 1 || o_err !== 1'b0 || o_other_bad !== 0)
            begin n_bad++; $display("FAIL slave.done got %0d err %0d other %0d want 1/0/0", o_ndone, o_err, o_other_bad); end
    endtask

    task automatic test_random_frames(input int nfr, input bit longest);
        int who;
        logic [7:0] len;
        for (int i = 0; i < nfr; i++) begin
            fill_tx();
            who = int'($urandom_range(0, 1));
            len = longest ? 8'hFF : 8'($urandom_range(0, 6));
            m_last = pick(who == 0, who == 1);
            do_frame(who, len, 1'($urandom), 1'b0, 1'b0, 1'b0, -1);
            n_vec++; if (o_timeout || o_gnt_cyc !== o_req_cyc + 1)
                begin n_bad++; $display("FAIL rand%0d.gnt got lat %0d to %0d want 1", i, o_gnt_cyc - o_req_cyc, o_timeout); end
            n_vec++; if (o_ndreq !== int'(len) + 1 || o_sent_ok !== int'(len) + 1)
                begin n_bad++; $display("FAIL rand%0d.tx got %0d dreq %0d good want %0d", i, o_ndreq, o_sent_ok, int'(len) + 1); end
            n_vec++; if (o_nrx !== int'(len) + 1 || o_rx_ok !== int'(len) + 1)
                begin n_bad++; $display("FAIL rand%0d.rx got %0d/%0d want %0d", i, o_nrx, o_rx_ok, int'(len) + 1); end
            n_vec++; if (o_ndone !== 1 || o_err !== 1'b0 || o_done_cyc !== o_fe_cyc + 1)
                begin n_bad++; $display("FAIL rand%0d.done got %0d err %0d lat %0d want 1/0/1", i, o_ndone, o_err, o_done_cyc - o_fe_cyc); end
            n_vec++; if (o_master_bad + o_timing_bad + o_other_bad !== 0 || !o_post_ok)
                begin n_bad++; $display("FAIL rand%0d.misc got %0d/%0d/%0d post %0d want 0/0/0/1", i, o_master_bad, o_timing_bad, o_other_bad, o_post_ok); end
        end
    endtask

    task automatic test_contention();
        int exp;
        logic [7:0] len;
        rst_i = 1'b1;
        bus.req0_i = 1'b1; bus.req1_i = 1'b1;
        quiet_core();
        repeat (2) tick();
        rst_i = 1'b0;
        m_last = 1;
        for (int i = 0; i < 4; i++) begin
            fill_tx();
            exp = pick(1, 1);
            m_last = exp;
            len = 8'($urandom_range(0, 3));
            do_frame(exp, len, 1'($urandom), 1'b1, 1'b0, 1'b0, -1);
            n_vec++; if (o_timeout || o_gnt_cyc !== o_req_cyc + 1)
                begin n_bad++; $display("FAIL contend%0d.order got gnt%0d lat %0d want gnt%0d lat 1", i, exp, o_gnt_cyc - o_req_cyc, exp); end
            n_vec++; if (o_overlap !== 0) begin n_bad++; $display("FAIL contend%0d.overlap got %0d want 0", i, o_overlap); end
            n_vec++; if (!o_post_ok) begin n_bad++; $display("FAIL contend%0d.gap got spi_en/gnt high after done want low", i); end
            n_vec++; if (o_ndone !== 1 || o_rx_ok !== int'(len) + 1)
                begin n_bad++; $display("FAIL contend%0d.bytes got done %0d rx %0d want 1/%0d", i, o_ndone, o_rx_ok, int'(len) + 1); end
        end
        bus.req0_i = 1'b0;
        bus.req1_i = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        fill_tx();
        m_last = pick(1, 0);
        do_frame(0, 8'd3, 1'b1, 1'b0, 1'b1, 1'b0, -1);
        n_vec++; if (o_ndone !== 1 || o_err !== 1'b1) begin n_bad++; $display("FAIL timeout.err got done %0d err %0d want 1/1", o_ndone, o_err); end
        n_vec++; if (o_done_cyc !== o_dreq_first + 2 + (2**TO_W - 1))
            begin n_bad++; $display("FAIL timeout.latency got %0d want %0d", o_done_cyc - o_dreq_first - 2, 2**TO_W - 1); end
        n_vec++; if (o_nrx !== 0 || o_ndreq !== 1) begin n_bad++; $display("FAIL timeout.discard got rx %0d dreq %0d want 0/1", o_nrx, o_ndreq); end
        n_vec++; if (!o_post_ok) begin n_bad++; $display("FAIL timeout.post got outputs high after done want low"); end
    endtask

    task automatic test_stray_status();
        fill_tx();
        m_last = pick(0, 1);
        do_frame(1, 8'd3, 1'b1, 1'b0, 1'b0, 1'b1, -1);
        n_vec++; if (o_ndreq !== 4 || o_sent_ok !== 4) begin n_bad++; $display("FAIL stray.tx got %0d/%0d want 4/4", o_ndreq, o_sent_ok); end
        n_vec++; if (o_nrx !== 4 || o_rx_ok !== 4) begin n_bad++; $display("FAIL stray.rx got %0d/%0d want 4/4", o_nrx, o_rx_ok); end
        n_vec++; if (o_ndone !== 1 || o_err !== 1'b0 || o_done_cyc !== o_fe_cyc + 1)
            begin n_bad++; $display("FAIL stray.done got %0d err %0d lat %0d want 1/0/1", o_ndone, o_err, o_done_cyc - o_fe_cyc); end
    endtask

    task automatic test_reset_mid_frame();
        int exp;
        fill_tx();
        m_last = pick(1, 0);
        do_frame(0, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0, 2);
        n_vec++; if (!o_rst_zero || o_ndone !== 0) begin n_bad++; $display("FAIL rstmid.outputs got zero %0d done %0d want 1/0", o_rst_zero, o_ndone); end
        m_last = 1;
        fill_tx();
        bus.req1_i = 1'b1; bus.len1_i = 8'd1; bus.mode1_i = 1'b0;
        exp = pick(1, 1);
        m_last = exp;
        do_frame(exp, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        n_vec++; if (o_timeout || o_gnt_cyc !== o_req_cyc + 1)
            begin n_bad++; $display("FAIL rstmid.first_grant got lat %0d to %0d want gnt%0d lat 1", o_gnt_cyc - o_req_cyc, o_timeout, exp); end
        fill_tx();
        m_last = pick(0, 1);
        do_frame(1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        n_vec++; if (o_ndone !== 1 || o_rx_ok !== 2) begin n_bad++; $display("FAIL rstmid.second got done %0d rx %0d want 1/2", o_ndone, o_rx_ok); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_slave_mode();
        test_random_frames(6, 1'b0);
        test_random_frames(1, 1'b1);
        test_contention();
        test_timeout();
        test_stray_status();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit reached at cycle %0d want finish earlier", cyc);
        $fatal(1, "time limit");
    end

endmodule
